// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the registered 1-to-2 demultiplexer.
//   DATA_W       : default datapath width (16 bits)
//   chan_e       : destination channel encoding (CH0 / CH1)
//   slot_state_e : occupancy of a one-entry output slot (EMPTY / FULL)
package demux_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry valid/ready output buffer used once per demux channel.
// Optional feature: `define DEMUX_STATS_EN to build a 16-bit delivered-word
// counter; without it, cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   fill       in   load fill_data into the slot this cycle
//   fill_data  in   word to load
//   can_accept out  slot is empty or is being drained this cycle
//   out_data   out  buffered word (stable while stalled)
//   out_valid  out  slot holds a word
//   out_ready  in   consumer accepts
//   cnt        out  words delivered (0 when stats are disabled)
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  output logic             can_accept,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt
);

  slot_state_e      state_p1;
  logic [WIDTH-1:0] data_p1;
  logic             drain;

  // Output transfer never completes while reset is asserted.
  assign drain      = (state_p1 == FULL) && out_ready && !rst;
  // A full slot that is draining now can take a new word in the same cycle.
  assign can_accept = (state_p1 == EMPTY) || out_ready;

  // ---- stage p1: slot register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= EMPTY;
      data_p1  <= '0;
    end else if (fill) begin
      state_p1 <= FULL;
      data_p1  <= fill_data;
    end else if (drain) begin
      state_p1 <= EMPTY;
    end
  end

  assign out_valid = (state_p1 == FULL);
  assign out_data  = data_p1;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_p1;

  // Wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (drain) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign cnt = cnt_p1;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/demux_2_reg.sv
// demux_2_reg: registered 1-to-2 demultiplexer. One word per cycle enters on
// a valid/ready channel and is steered by in_sel (captured with the word) into
// one of two single-entry output buffers, each drained by its own handshake.
// Optional feature: `define DEMUX_STATS_EN enables per-channel delivered-word
// counters on cnt0/cnt1; otherwise those ports read zero.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_data, in_sel, in_valid      input word, destination, valid
//   in_ready                       input accepted this cycle when valid
//   out0_data/valid/ready          channel 0 output handshake
//   out1_data/valid/ready          channel 1 output handshake
//   cnt0, cnt1                     delivered-word counters
module demux_2_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  chan_e sel;
  logic  accept0;
  logic  accept1;
  logic  xfer;
  logic  fill0;
  logic  fill1;

  assign sel = chan_e'(in_sel);

  // Readiness follows whatever in_sel currently points at, so a stalled
  // producer may retarget its word to the other channel.
  assign in_ready = (sel == CH1) ? accept1 : accept0;
  assign xfer     = in_valid && in_ready;
  assign fill0    = xfer && (sel == CH0);
  assign fill1    = xfer && (sel == CH1);

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .fill       (fill0),
    .fill_data  (in_data),
    .can_accept (accept0),
    .out_data   (out0_data),
    .out_valid  (out0_valid),
    .out_ready  (out0_ready),
    .cnt        (cnt0)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .fill       (fill1),
    .fill_data  (in_data),
    .can_accept (accept1),
    .out_data   (out1_data),
    .out_valid  (out1_valid),
    .out_ready  (out1_ready),
    .cnt        (cnt1)
  );

endmodule
